counter_sched: RTL
==================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter WIDTH, default 4: width of the counting datapath, the job lengths and the count output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester job request; req[i] is held high until gnt[i] is seen.
REQ-005 len0  input  WIDTH  job length for requester 0; sampled only when the job is accepted.
REQ-006 len1  input  WIDTH  job length for requester 1; sampled only when the job is accepted.
REQ-007 gnt  output  2  one-hot ownership of the shared counter; all zero when idle.
REQ-008 en  output  1  counter-enable strobe; high in every cycle in which count increments.
REQ-009 count  output  WIDTH  shared counter value.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking job completion.
REQ-012 done_id  output  1  index of the requester that owned the completed job; valid while done=1.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-014 IDLE: if any req bit is set, the block SHALL select a winner, latch the winner's len into len_q, and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin.
  - Only one request: that requester wins.
  - Both requesting: the requester not served most recently wins.
  - After reset, requester 0 has priority.
REQ-016 gnt[winner] SHALL be high from the LOAD cycle through the DONE cycle inclusive, and low otherwise.
REQ-017 LOAD: count SHALL be set to 0. Next state SHALL be DONE if len_q==0, else RUN.
REQ-018 RUN: en=1 and count SHALL increment by 1 each cycle. When count+1==len_q, next state SHALL be DONE.
REQ-019 Count SHALL never exceed len_q and SHALL never wrap. Length 2^WIDTH-1 is legal.
REQ-020 DONE: done=1, done_id=winner, and count SHALL hold its final value (len_q). Next state SHALL be IDLE; in IDLE, count SHALL keep its last value.
REQ-021 Latency: a job of length L>0 accepted at IDLE cycle t SHALL produce LOAD at t+1, RUN at t+2..t+L+1 and done at t+L+2. For L=0, done SHALL be at t+2.
REQ-022 req bits and len inputs SHALL be ignored while busy=1. A requester that drops req before being granted SHALL lose its request with no side effects.
REQ-023 A back-to-back request from the same requester SHALL be re-arbitrated in IDLE, so the other requester is served first if it is pending.

Reset
REQ-024 With rst=1 at a clock edge, the block SHALL enter IDLE, and all outputs and internal state SHALL take the reset values below:
  - count=0
  - gnt=2'b00, en=0, busy=0, done=0, done_id=0
  - round-robin priority to requester 0, len_q=0
REQ-025 Reset during LOAD, RUN or DONE SHALL abort the job silently, with no done pulse. Reset SHALL take precedence over every other input.

Configuration
REQ-026 Macro COUNTER_SCHED_ABORT_EN compiled in SHALL add:
  - input abort, 1 bit;
  - output aborted, 1 bit.
REQ-027 With COUNTER_SCHED_ABORT_EN, abort=1 in LOAD or RUN SHALL force next state DONE with count frozen, and aborted=1 alongside done. In IDLE and DONE, abort SHALL be ignored. Reset value of aborted SHALL be 0.
REQ-028 Without COUNTER_SCHED_ABORT_EN:
  - the abort and aborted ports SHALL be absent;
  - every job SHALL run to len_q.

Verification
REQ-029 Single job: req=01, len0=3 -> gnt=01 for 5 cycles, count 0,1,2,3, en high 3 cycles, done at t+5 with done_id=0.
REQ-030 Contention: req=11 held after reset, len0=2, len1=4 -> requester 0 served first, then requester 1; done_id sequence 0,1; gnt never 11.
REQ-031 Zero and max length: len1=0 -> done at t+2 with count=0; len0=15 (WIDTH=4) -> 15 en cycles, final count 15, no wrap to 0.
REQ-032 Reset mid-RUN: len0=10, rst at count=4 -> next cycle count=0, gnt=00, busy=0, no done pulse; a new request is then served by requester 0 first.
REQ-033 Abort (COUNTER_SCHED_ABORT_EN): len1=9, abort at count=5 -> DONE next cycle, done=1 and aborted=1, count=6 held.
REQ-034 Ignored inputs: change len0 and pulse req[1] while busy -> in-flight job unaffected; req[1] dropped before IDLE is never granted.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler granting a shared up-counter to one of
// two requesters; each job counts from 0 up to its latched length.
// Optional feature: define COUNTER_SCHED_ABORT_EN to add the abort input and
// the aborted output (early job termination from LOAD or RUN).
module counter_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       gnt,
  output logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q,   len_d;
  logic             win_q,   win_d;   // owner of the current job
  logic             prio_q,  prio_d;  // requester favoured on a tie
  logic             abort_c;

`ifdef COUNTER_SCHED_ABORT_EN
  logic             abt_q,   abt_d;   // current job ended by abort
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: counter, latched length, owner, round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      len_q   <= '0;
      win_q   <= 1'b0;
      prio_q  <= 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
      abt_q   <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      len_q   <= len_d;
      win_q   <= win_d;
      prio_q  <= prio_d;
`ifdef COUNTER_SCHED_ABORT_EN
      abt_q   <= abt_d;
`endif
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    win_d   = win_q;
    prio_d  = prio_q;
`ifdef COUNTER_SCHED_ABORT_EN
    abt_d   = abt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          // Tie goes to the pointer; a lone request wins outright.
          win_d   = (req == 2'b11) ? prio_q : req[1];
          len_d   = win_d ? len1 : len0;
          prio_d  = ~win_d;
          count_d = '0;
`ifdef COUNTER_SCHED_ABORT_EN
          abt_d   = 1'b0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort_c || (len_q == '0)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
`ifdef COUNTER_SCHED_ABORT_EN
        abt_d = abort_c;
`endif
      end
      RUN: begin
        // RUN is only entered with len_q >= 1, so count_q + 1 never wraps.
        count_d = count_q + WIDTH'(1);
        if (abort_c || (count_d == len_q)) begin
          state_d = DONE;
        end
`ifdef COUNTER_SCHED_ABORT_EN
        abt_d = abort_c;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy    = (state_q != IDLE);
    gnt     = busy ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    en      = (state_q == RUN);
    done    = (state_q == DONE);
    done_id = done & win_q;
    count   = count_q;
`ifdef COUNTER_SCHED_ABORT_EN
    aborted = done & abt_q;
`endif
  end

endmodule
